// File: rtl/lsu_addr_guard.sv
// Address guard between the LSU and the data-side bus: checks alignment and the legal
// load/store map, forwards legal requests over valid/ready and answers illegal ones locally.
module lsu_addr_guard #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,

    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        rsp_skip_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFwd  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [1:0] ErrOk    = 2'd0;
    localparam logic [1:0] ErrAlign = 2'd1;
    localparam logic [1:0] ErrFault = 2'd2;
    localparam logic [1:0] ErrBus   = 2'd3;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    logic [1:0]  state_q, state_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic        rsp_skip_q, rsp_skip_d;
    logic [15:0] cnt_q, cnt_d;

    // Region decode of the incoming request address
    logic hit_sram, hit_flash, hit_sdram, hit_clint, hit_uart, hit_gpio, hit_ps2, hit_vga;
    logic hit_npc;
    logic load_ok, store_ok, map_ok, skip_hit, misaligned, timeout_hit;

    assign hit_sram  = in_range(req_addr_i, 32'h0F00_0000, 32'h0F00_1FFF);
    assign hit_flash = in_range(req_addr_i, 32'h3000_0000, 32'h30FF_FFFF);
    assign hit_sdram = in_range(req_addr_i, 32'hA000_0000, 32'hA3FF_FFFF);
    assign hit_clint = in_range(req_addr_i, 32'h0200_0000, 32'h0200_FFFF);
    assign hit_uart  = in_range(req_addr_i, 32'h1000_0000, 32'h1000_0FFF);
    assign hit_gpio  = in_range(req_addr_i, 32'h1000_2000, 32'h1000_200F);
    assign hit_ps2   = in_range(req_addr_i, 32'h1001_1000, 32'h1001_1007);
    assign hit_vga   = in_range(req_addr_i, 32'h2100_0000, 32'h211F_FFFF);
`ifdef NPC_MODE
    assign hit_npc   = in_range(req_addr_i, 32'h8000_0000, 32'h87FF_FFFF);
`else
    assign hit_npc   = 1'b0;
`endif

    assign store_ok = hit_sram | hit_sdram | hit_uart | hit_gpio | hit_vga | hit_npc;
    assign load_ok  = store_ok | hit_flash | hit_clint | hit_ps2;
    assign map_ok   = req_we_i ? store_ok : load_ok;
    assign skip_hit = hit_clint | hit_uart | hit_gpio | hit_ps2 | hit_vga;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Counter is compared before incrementing, so WAIT lasts TIMEOUT + 1 cycles
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT);

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_skip_d  = rsp_skip_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    bus_we_d    = req_we_i;
                    bus_addr_d  = req_addr_i;
                    bus_wdata_d = req_wdata_i;
                    bus_wstrb_d = req_wstrb_i;
                    rsp_skip_d  = skip_hit;
                    rsp_rdata_d = 32'd0;
                    cnt_d       = 16'd0;
                    if (misaligned) begin
                        rsp_err_d   = ErrAlign;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end else if (!map_ok) begin
                        rsp_err_d   = ErrFault;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end else begin
                        rsp_err_d   = ErrOk;
                        bus_valid_d = 1'b1;
                        state_d     = StFwd;
                    end
                end
            end
            StFwd: begin
                if (bus_ready_i) begin
                    bus_valid_d = 1'b0;
                    cnt_d       = 16'd0;
                    if (bus_rvalid_i) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = bus_err_i ? ErrBus : ErrOk;
                        rsp_rdata_d = (bus_err_i || bus_we_q) ? 32'd0 : bus_rdata_i;
                        state_d     = StResp;
                    end else begin
                        state_d     = StWait;
                    end
                end
            end
            StWait: begin
                if (bus_rvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err_i ? ErrBus : ErrOk;
                    rsp_rdata_d = (bus_err_i || bus_we_q) ? 32'd0 : bus_rdata_i;
                    state_d     = StResp;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ErrBus;
                    rsp_rdata_d = 32'd0;
                    state_d     = StResp;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'd0;
            rsp_skip_q  <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_skip_q  <= rsp_skip_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign bus_valid_o = bus_valid_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_skip_o  = rsp_skip_q;

endmodule
